// File: rtl/therm_adc_sampler.sv
// Thermistor ADC front-end: clocks an MCP3001-style serial ADC, averages
// 2^AVG_LOG2 conversions and publishes the top OUT_BITS of the mean.
module therm_adc_sampler #(
  parameter int CLK_DIV    = 4,
  parameter int ADC_BITS   = 10,
  parameter int AVG_LOG2   = 3,
  parameter int SAMPLE_GAP = 1000,
  parameter int OUT_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                adc_miso,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic [OUT_BITS-1:0] v_therm,
  output logic                v_valid,
  output logic                busy
);

  localparam int HALF_N  = 2 * (ADC_BITS + 2);
  localparam int HALF_W  = $clog2(HALF_N);
  localparam int DIV_MAX = (SAMPLE_GAP > CLK_DIV) ? SAMPLE_GAP : CLK_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX) + 1;
  localparam int ACC_W   = ADC_BITS + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  GAP_LAST   = DIV_W'(SAMPLE_GAP - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALF_N - 1);
  localparam logic [HALF_W-1:0] DATA_HALF  = HALF_W'(5);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, ACCUM, GAP} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt, div_nxt;
  logic [HALF_W-1:0]   half_cnt, half_nxt;
  logic                sclk_nxt, cs_n_nxt, sample_now, group_done;
  logic [ADC_BITS-1:0] shift_reg;
  logic [ACC_W-1:0]    acc, sum;
  logic [CNT_W-1:0]    cnt;

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    half_nxt  = half_cnt;
    case (state)
      IDLE: begin
        div_nxt  = '0;
        half_nxt = '0;
        if (enable) state_nxt = CS_SETUP;
      end
      CS_SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          half_nxt  = '0;
          state_nxt = SHIFT;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        // half_cnt walks the SCLK half-periods; odd halves are SCLK high
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (half_cnt == HALF_LAST) state_nxt = CS_HOLD;
          else                       half_nxt  = half_cnt + 1'b1;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      CS_HOLD: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          state_nxt = ACCUM;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ACCUM: begin
        div_nxt   = '0;
        state_nxt = GAP;
      end
      GAP: begin
        if (div_cnt == GAP_LAST) begin
          div_nxt   = '0;
          state_nxt = enable ? CS_SETUP : IDLE;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pins are registered from the next-state decode so they stay glitch-free
  assign sclk_nxt   = (state_nxt == SHIFT) && half_nxt[0];
  assign cs_n_nxt   = !((state_nxt == CS_SETUP) || (state_nxt == SHIFT) || (state_nxt == CS_HOLD));
  assign sample_now = sclk_nxt && !adc_sclk && (half_nxt >= DATA_HALF);
  assign sum        = acc + ACC_W'(shift_reg);
  assign group_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      half_cnt <= half_nxt;
      adc_cs_n <= cs_n_nxt;
      adc_sclk <= sclk_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  // The mean's top bits are sum's top bits, so no explicit shift is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      v_therm   <= '0;
      v_valid   <= 1'b0;
    end else begin
      v_valid <= 1'b0;
      if (sample_now) shift_reg <= {shift_reg[ADC_BITS-2:0], adc_miso};
      if (state == ACCUM) begin
        if (group_done) begin
          v_therm <= sum[ACC_W-1 -: OUT_BITS];
          v_valid <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end else if (state_nxt == IDLE) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_therm_adc_sampler.sv
// Self-checking bench for therm_adc_sampler: serial ADC model, vector table,
// stop/restart sequence and a randomized run against a mean-of-four reference.
module tb_therm_adc_sampler;

  localparam int CLK_DIV    = 2;
  localparam int ADC_BITS   = 10;
  localparam int AVG_LOG2   = 2;
  localparam int SAMPLE_GAP = 8;
  localparam int OUT_BITS   = 4;
  localparam int GROUP_BUDGET = 4 * 61 + 40;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                adc_miso = 1'b0;
  logic                adc_sclk, adc_cs_n, v_valid, busy;
  logic [OUT_BITS-1:0] v_therm;

  therm_adc_sampler #(
    .CLK_DIV(CLK_DIV), .ADC_BITS(ADC_BITS), .AVG_LOG2(AVG_LOG2),
    .SAMPLE_GAP(SAMPLE_GAP), .OUT_BITS(OUT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_miso(adc_miso),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .v_therm(v_therm),
    .v_valid(v_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][9:0] s;
    logic            null_bit;
    logic [3:0]      exp_v;
  } vec_t;

  int assertions = 0;
  int failures = 0;

  // ADC model: each frame pops {null_bit, data}; bits change on SCLK fall
  logic [10:0] data_q[$];
  logic [10:0] cur_word;
  logic [11:0] frame_bits;
  int          bit_idx = 0;
  bit          frame_open = 1'b0;

  always @(negedge adc_cs_n or posedge adc_cs_n or negedge adc_sclk) begin
    if (adc_cs_n !== 1'b0) begin
      frame_open = 1'b0;
    end else if (!frame_open) begin
      cur_word   = (data_q.size() > 0) ? data_q.pop_front() : 11'h000;
      frame_bits = {cur_word[10], cur_word[10], cur_word[9:0]};
      bit_idx    = 0;
      frame_open = 1'b1;
      adc_miso   = frame_bits[11];
    end else begin
      bit_idx = bit_idx + 1;
      if (bit_idx < 12) adc_miso = frame_bits[11 - bit_idx];
    end
  end

  // Pin-level timing monitor sampled on the falling clock edge
  int   cyc = 0, cs_fall_cnt = 0, cs_rise_cnt = 0, vv_cnt = 0;
  int   last_fall = 0, low_start = 0, cs_low_len = 0, period = 0;
  int   sclk_rises = 0, frame_rises = 0, last_rise = 0, hi_start = 0, hi_len = 0;
  int   rr_min = 1000, rr_max = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      cs_fall_cnt = cs_fall_cnt + 1;
      period      = cyc - last_fall;
      last_fall   = cyc;
      low_start   = cyc;
      sclk_rises  = 0;
      rr_min      = 1000;
      rr_max      = 0;
    end
    if (prev_cs === 1'b0 && adc_cs_n === 1'b1) begin
      cs_rise_cnt = cs_rise_cnt + 1;
      cs_low_len  = cyc - low_start;
      frame_rises = sclk_rises;
    end
    if (prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
      if (sclk_rises > 0) begin
        if (cyc - last_rise < rr_min) rr_min = cyc - last_rise;
        if (cyc - last_rise > rr_max) rr_max = cyc - last_rise;
      end
      sclk_rises = sclk_rises + 1;
      last_rise  = cyc;
      hi_start   = cyc;
    end
    if (prev_sclk === 1'b1 && adc_sclk === 1'b0) hi_len = cyc - hi_start;
    if (v_valid === 1'b1) vv_cnt = vv_cnt + 1;
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                                 input logic [9:0] d, input logic nb, input logic [3:0] e);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.null_bit = nb;
    v.exp_v = e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < 4; i++) data_q.push_back({v.null_bit, v.s[i]});
  endtask

  task automatic waitValid(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (v_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, " v_valid seen"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      @(negedge clk);
      checkOutput({name, " v_valid one cycle"}, {31'd0, v_valid}, 32'd0);
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, " reached idle"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[9];
  int   rs[100];
  int   f0, r0, v0, sum4;
  bit   ok;

  initial begin
    vecs[0] = mkVec(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 4'hF);
    vecs[1] = mkVec(10'h200, 10'h200, 10'h200, 10'h1FC, 1'b0, 4'h7);
    vecs[2] = mkVec(10'h000, 10'h000, 10'h000, 10'h000, 1'b0, 4'h0);
    vecs[3] = mkVec(10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 4'h0);
    vecs[4] = mkVec(10'h3C0, 10'h3C0, 10'h3C0, 10'h3C0, 1'b1, 4'hF);
    vecs[5] = mkVec(10'h040, 10'h040, 10'h040, 10'h03F, 1'b0, 4'h0);
    vecs[6] = mkVec(10'h080, 10'h080, 10'h080, 10'h07F, 1'b0, 4'h1);
    vecs[7] = mkVec(10'h155, 10'h2AA, 10'h155, 10'h2AA, 1'b1, 4'h7);
    vecs[8] = mkVec(10'h280, 10'h280, 10'h280, 10'h280, 1'b0, 4'hA);

    repeat (3) @(negedge clk);
    checkOutput("reset cs_n", {31'd0, adc_cs_n}, 32'd1);
    checkOutput("reset sclk", {31'd0, adc_sclk}, 32'd0);
    checkOutput("reset v_therm", {28'd0, v_therm}, 32'd0);
    checkOutput("reset v_valid", {31'd0, v_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] frame timing with full-scale samples");
    applyStimulus(vecs[0]);
    r0 = cs_rise_cnt;
    enable = 1'b1;
    waitValid(GROUP_BUDGET, "timing");
    checkOutput("timing frames before valid", cs_rise_cnt - r0, 32'd4);
    checkOutput("timing v_therm", {28'd0, v_therm}, 32'hF);
    checkOutput("timing cs_n low cycles", cs_low_len, 32'd52);
    checkOutput("timing sclk pulses", frame_rises, 32'd12);
    checkOutput("timing sclk period min", rr_min, 32'd4);
    checkOutput("timing sclk period max", rr_max, 32'd4);
    checkOutput("timing sclk high cycles", hi_len, 32'd2);
    checkOutput("timing sample period", period, 32'd61);

    $display("[TB] asynchronous reset during SHIFT");
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (adc_sclk === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("reset sclk seen high", {31'd0, ok}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset cs_n", {31'd0, adc_cs_n}, 32'd1);
    checkOutput("async reset sclk", {31'd0, adc_sclk}, 32'd0);
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset v_therm", {28'd0, v_therm}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vv_cnt;
    repeat (10) @(negedge clk);
    checkOutput("post reset busy", {31'd0, busy}, 32'd0);
    checkOutput("post reset v_therm", {28'd0, v_therm}, 32'd0);
    checkOutput("post reset no v_valid", vv_cnt - v0, 32'd0);
    checkOutput("post reset cs_n", {31'd0, adc_cs_n}, 32'd1);

    $display("[TB] vector table");
    data_q.delete();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      r0 = cs_rise_cnt;
      if (i == 0) enable = 1'b1;
      waitValid(GROUP_BUDGET, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d v_therm", i), {28'd0, v_therm}, {28'd0, vecs[i].exp_v});
      checkOutput($sformatf("vec%0d frames", i), cs_rise_cnt - r0, 32'd4);
    end

    $display("[TB] stop during second frame");
    data_q.push_back({1'b0, 10'h3FF});
    data_q.push_back({1'b0, 10'h3FF});
    f0 = cs_fall_cnt;
    r0 = cs_rise_cnt;
    v0 = vv_cnt;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cs_fall_cnt >= f0 + 2) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("stop second frame started", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    waitIdle(200, "stop");
    checkOutput("stop frame completed", cs_rise_cnt - r0, 32'd2);
    checkOutput("stop no v_valid", vv_cnt - v0, 32'd0);
    checkOutput("stop v_therm holds", {28'd0, v_therm}, 32'hA);
    checkOutput("stop cs_n", {31'd0, adc_cs_n}, 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("stop stays idle", {31'd0, busy}, 32'd0);
    checkOutput("stop no new frames", cs_fall_cnt - f0, 32'd2);
    checkOutput("stop v_therm still holds", {28'd0, v_therm}, 32'hA);

    $display("[TB] re-enable needs four fresh frames");
    data_q.delete();
    for (int i = 0; i < 4; i++) data_q.push_back({1'b0, 10'h100});
    f0 = cs_fall_cnt;
    enable = 1'b1;
    waitValid(GROUP_BUDGET, "restart");
    checkOutput("restart frames", cs_fall_cnt - f0, 32'd4);
    checkOutput("restart v_therm", {28'd0, v_therm}, 32'h4);

    $display("[TB] continuous random run");
    for (int i = 0; i < 100; i++) begin
      rs[i] = int'($urandom_range(0, 1023));
      data_q.push_back({1'($urandom_range(0, 1)), 10'(rs[i])});
    end
    v0 = vv_cnt;
    for (int g = 0; g < 25; g++) begin
      waitValid(GROUP_BUDGET, $sformatf("rand%0d", g));
      sum4 = rs[4*g] + rs[4*g+1] + rs[4*g+2] + rs[4*g+3];
      checkOutput($sformatf("rand%0d v_therm", g), {28'd0, v_therm}, (sum4 / 4) / 64);
    end
    enable = 1'b0;
    checkOutput("rand pulse count", vv_cnt - v0, 32'd25);
    waitIdle(200, "rand end");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
